// File: rtl/logic_accum.sv
// Bitwise logic unit with an optional accumulator feedback path, a valid/ready
// output register and an accepted-beat counter. Define LOGIC_ACCUM_REDUCE_EN to add out_any/out_all.
module logic_accum #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             accum,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [CNT_W-1:0] beat_cnt
`ifdef LOGIC_ACCUM_REDUCE_EN
   ,
   output logic             out_any,
   output logic             out_all
`endif
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] eff_b;
   logic [WIDTH-1:0] result;
   logic             accept;

   function automatic logic bit_op(input logic [2:0] sel, input logic x, input logic y);
      logic r;
      r = 1'b0;
      case (sel)
         3'b000:  r = x & y;
         3'b001:  r = x | y;
         3'b010:  r = x ^ y;
         3'b011:  r = ~(x & y);
         3'b100:  r = ~(x | y);
         3'b101:  r = ~(x ^ y);
         3'b110:  r = x;
         default: r = ~x;
      endcase
      return r;
   endfunction

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // A clear arriving with an accumulate beat starts the new chain from zero.
   always_comb begin
      eff_b = b;
      if (accum) begin
         eff_b = clear ? '0 : acc_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign result[gi] = bit_op(op, a[gi], eff_b[gi]);
      end
   endgenerate

   always_comb begin
      acc_d       = acc_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;
      if (accept) begin
         acc_d       = result;
         out_d       = result;
         out_valid_d = 1'b1;
         cnt_d       = clear ? CNT_W'(1) : cnt_q + CNT_W'(1);
      end else begin
         if (out_ready) begin
            out_valid_d = 1'b0;
         end
         if (clear) begin
            acc_d = '0;
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         acc_q       <= acc_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign beat_cnt  = cnt_q;

`ifdef LOGIC_ACCUM_REDUCE_EN
   logic any_q, any_d;
   logic all_q, all_d;

   // Reductions are taken from the incoming result so they line up with out.
   always_comb begin
      any_d = any_q;
      all_d = all_q;
      if (accept) begin
         any_d = |result;
         all_d = &result;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         any_q <= 1'b0;
         all_q <= 1'b0;
      end else begin
         any_q <= any_d;
         all_q <= all_d;
      end
   end

   assign out_any = any_q;
   assign out_all = all_q;
`endif

endmodule

// File: tb/tb_logic_accum.sv
// Scoreboard bench for logic_accum: stimulus pushes expected results, a monitor
// pops them on every output transfer. Define LOGIC_ACCUM_REDUCE_EN to exercise out_any/out_all.
module tb_logic_accum;

   typedef struct {
      logic [15:0] res;
      logic [7:0]  cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [2:0]  op;
   logic        accum;
   logic        clear;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out;
   logic [7:0]  beat_cnt;
`ifdef LOGIC_ACCUM_REDUCE_EN
   logic        out_any;
   logic        out_all;
`endif

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   logic_accum #(.WIDTH(16), .CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .accum     (accum),
      .clear     (clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .beat_cnt  (beat_cnt)
`ifdef LOGIC_ACCUM_REDUCE_EN
      ,
      .out_any   (out_any),
      .out_all   (out_all)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every output transfer must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("mon_unexpected_output", 32'(out), 32'hDEAD_BEEF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mon_out", 32'(out), 32'(e.res));
            chk("mon_beat_cnt", 32'(beat_cnt), 32'(e.cnt));
            $display("xfer out=%h beat_cnt=%h expected=%h/%h", out, beat_cnt, e.res, e.cnt);
         end
      end
   end

   // Offer one beat, wait for acceptance, then check the 1-cycle latency result.
   task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic [2:0] top,
                       input logic tacc, input logic tclr,
                       input logic [15:0] eo, input logic [7:0] ec);
      bit got;
      exp_t e;
      got      = 1'b0;
      in_valid = 1'b1;
      a        = ta;
      b        = tb_v;
      op       = top;
      accum    = tacc;
      clear    = tclr;
      e.res    = eo;
      e.cnt    = ec;
      exp_q.push_back(e);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
      if (!got) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else begin
         chk("lat_out_valid", 32'(out_valid), 32'd1);
         chk("lat_out", 32'(out), 32'(eo));
         chk("lat_beat_cnt", 32'(beat_cnt), 32'(ec));
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      clear    = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      op       = 3'($urandom);
      accum    = 1'($urandom);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      op        = '0;
      accum     = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // All eight operations, back to back with out_ready held high.
      send(16'hA5A5, 16'h5A5A, 3'b001, 1'b0, 1'b0, 16'hFFFF, 8'd1);
      send(16'hA5A5, 16'h5A5A, 3'b000, 1'b0, 1'b0, 16'h0000, 8'd2);
      send(16'hA5A5, 16'h5A5A, 3'b010, 1'b0, 1'b0, 16'hFFFF, 8'd3);
      send(16'hA5A5, 16'h5A5A, 3'b100, 1'b0, 1'b0, 16'h0000, 8'd4);
      send(16'hA5A5, 16'h5A5A, 3'b011, 1'b0, 1'b0, 16'hFFFF, 8'd5);
      send(16'hA5A5, 16'h5A5A, 3'b101, 1'b0, 1'b0, 16'h0000, 8'd6);
      send(16'hA5A5, 16'h5A5A, 3'b110, 1'b0, 1'b0, 16'hA5A5, 8'd7);
      send(16'hA5A5, 16'h5A5A, 3'b111, 1'b0, 1'b0, 16'h5A5A, 8'd8);

      // Accumulate chain starting from a clear.
      send(16'h0001, 16'hFFFF, 3'b001, 1'b1, 1'b1, 16'h0001, 8'd1);
      send(16'h0010, 16'hFFFF, 3'b001, 1'b1, 1'b0, 16'h0011, 8'd2);
      send(16'h8000, 16'hFFFF, 3'b001, 1'b1, 1'b0, 16'h8011, 8'd3);

      // Clear without accept, then idle junk must not disturb acc.
      idle(1);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      chk("clear_beat_cnt", 32'(beat_cnt), 32'd0);
      idle(3);
      send(16'h1234, 16'hFFFF, 3'b001, 1'b1, 1'b0, 16'h1234, 8'd1);
      idle(1);

      // Backpressure: first beat lands, second waits until out_ready rises.
      out_ready = 1'b0;
      send(16'h00FF, 16'h0F0F, 3'b010, 1'b0, 1'b0, 16'h0FF0, 8'd2);
      in_valid = 1'b1;
      a        = 16'h1111;
      b        = 16'h2222;
      op       = 3'b001;
      accum    = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_hold", 32'(out), 32'h0FF0);
         chk("bp_valid_hold", 32'(out_valid), 32'd1);
         chk("bp_cnt_hold", 32'(beat_cnt), 32'd2);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(16'h1111, 16'h2222, 3'b001, 1'b0, 1'b0, 16'h3333, 8'd3);

      // Counter wrap: 256 beats from zero return to 00, the next gives 01.
      idle(1);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      for (int i = 0; i < 257; i++) begin
         send(16'(i), 16'h0000, 3'b110, 1'b0, 1'b0, 16'(i), 8'(i + 1));
      end
      chk("wrap_final_cnt", 32'(beat_cnt), 32'h01);

      // Reset mid-operation with a pending result and a beat on offer.
      idle(1);
      send(16'h8011, 16'h0000, 3'b110, 1'b1, 1'b1, 16'h8011, 8'd1);
      out_ready = 1'b0;
      reset     = 1'b1;
      in_valid  = 1'b1;
      a         = 16'h4321;
      op        = 3'b001;
      accum     = 1'b1;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out", 32'(out), 32'd0);
      chk("mid_rst_beat_cnt", 32'(beat_cnt), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      send(16'h0001, 16'hFFFF, 3'b001, 1'b1, 1'b0, 16'h0001, 8'd1);

`ifdef LOGIC_ACCUM_REDUCE_EN
      send(16'h0000, 16'h0000, 3'b110, 1'b0, 1'b0, 16'h0000, 8'd2);
      chk("red_any_0000", 32'(out_any), 32'd0);
      chk("red_all_0000", 32'(out_all), 32'd0);
      send(16'h0400, 16'h0000, 3'b110, 1'b0, 1'b0, 16'h0400, 8'd3);
      chk("red_any_0400", 32'(out_any), 32'd1);
      chk("red_all_0400", 32'(out_all), 32'd0);
      send(16'hFFFF, 16'h0000, 3'b110, 1'b0, 1'b0, 16'hFFFF, 8'd4);
      chk("red_any_ffff", 32'(out_any), 32'd1);
      chk("red_all_ffff", 32'(out_all), 32'd1);
`endif

      idle(3);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/logic_accum.md
LOGIC_ACCUM -- requirements
Module: logic_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits (legal range 1..64).
REQ-002 SHALL have parameter CNT_W, default 8, width of the accepted-beat counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL change only on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, indicating an input beat is offered.
REQ-006 SHALL have port in_ready, output, 1, indicating the block accepts a beat this cycle.
REQ-007 SHALL have port a, input, WIDTH, operand A.
REQ-008 SHALL have port b, input, WIDTH, operand B.
REQ-009 SHALL have port op, input, 3, operation select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 PASS a, 111 NOT a.
REQ-010 SHALL have port accum, input, 1, which substitutes the accumulator for operand B when high.
REQ-011 SHALL have port clear, input, 1, a synchronous clear of the accumulator and the counter.
REQ-012 SHALL have port out_valid, output, 1, indicating the result register holds valid data.
REQ-013 SHALL have port out_ready, input, 1, indicating downstream accepts the result.
REQ-014 SHALL have port out, output, WIDTH, the registered result.
REQ-015 SHALL have port beat_cnt, output, CNT_W, the count of accepted beats.

Function
REQ-016 SHALL assert in_ready exactly when (!out_valid || out_ready), combinationally.
REQ-017 SHALL accept a beat when in_valid && in_ready are both high in the same cycle ("accept").
REQ-018 SHALL form the effective B operand as b when accum=0; as acc when accum=1, clear=0; and as all-zero when accum=1, clear=1.
REQ-019 SHALL, on accept, register op(a, effective B) into out and set out_valid=1 on the next edge, giving a latency of 1 cycle.
REQ-020 SHALL, on accept, load acc with the same result value; when there is no accept, acc SHALL hold, except under clear.
REQ-021 SHALL, when clear=1 without an accept, set acc to 0 and beat_cnt to 0.
REQ-022 SHALL, when clear=1 and an accept occur in the same cycle, compute the result per REQ-018, load acc with that result, and set beat_cnt to 1.
REQ-023 SHALL increment beat_cnt by 1 on each accept without clear, wrapping from 2^CNT_W-1 to 0.
REQ-024 SHALL clear out_valid when out_valid && out_ready && !in_valid.
REQ-025 SHALL, when out_valid && out_ready && accept occur together, replace out with the new result and keep out_valid=1, giving full throughput with no bubble.
REQ-026 SHALL hold out and out_valid stable while out_valid=1 and out_ready=0; in_ready SHALL be 0 in that case.
REQ-027 SHALL ignore a, b, op and accum when there is no accept.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, set out_valid=0, out=0, acc=0 and beat_cnt=0.
REQ-029 SHALL give reset priority over accept and clear, discarding any in-flight or simultaneously offered beat.
REQ-030 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-031 SHALL, when macro LOGIC_ACCUM_REDUCE_EN is defined, add output ports out_any (1, the OR of all out bits) and out_all (1, the AND of all out bits); these SHALL be registered alongside out, be 0 at reset, and be valid whenever out_valid=1.
REQ-032 SHALL, when LOGIC_ACCUM_REDUCE_EN is undefined, omit out_any and out_all entirely, with no reduction logic and all other behaviour unchanged.

Verification (WIDTH=16, CNT_W=8)
REQ-033 SHALL cover ops: out_ready=1, beats a=A5A5 b=5A5A with op=001, 000, 010 and 100 -> out FFFF, 0000, FFFF, 0000 on consecutive cycles, one cycle after each accept.
REQ-034 SHALL cover accumulate: clear+accum beat a=0001 op=001, then accum beats a=0010, then a=8000 -> out 0001, 0011, 8011; beat_cnt 1, 2, 3.
REQ-035 SHALL cover backpressure: out_ready=0, two beats offered -> first accepted, out holds the value and in_ready=0 until out_ready=1; second result appears the cycle after its accept; no beat lost or duplicated.
REQ-036 SHALL cover wrap: 256 accepted beats with no clear -> beat_cnt returns to 00; 257th beat -> 01.
REQ-037 SHALL cover reset mid-operation: acc=8011, out_valid=1, reset with in_valid=1 -> next cycle out_valid=0, out=0000, beat_cnt=00; the following accum beat a=0001 op=001 -> out 0001.
REQ-038 SHALL cover the macro (with LOGIC_ACCUM_REDUCE_EN): results 0000, 0400 and FFFF -> out_any/out_all equal 0/0, 1/0 and 1/1 respectively.
